cache_controller: RTL

//  2-way set-associative read cache between the MEM stage and the SRAM controller.

---
 rtl/cache_controller.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/cache_controller.sv
// 2-way set-associative, write-through / no-write-allocate read cache sitting
// between the MEM stage and the SRAM controller (one 64-bit line per fill).
`timescale 1ns/1ps

module cache_controller #(
    parameter logic [31:0] BASE_ADDR = 32'd1024,
    parameter int          SETS      = 64,
    parameter int          TAG_W     = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        ready,
    output logic        sram_r_en,
    output logic        sram_w_en,
    output logic [31:0] sram_address,
    output logic [31:0] sram_wdata,
    input  logic [63:0] sram_rdata,
    input  logic        sram_ready
);

    localparam int IDX_W = $clog2(SETS);
    localparam int EFF_W = 1 + IDX_W + TAG_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t             state_q;
    logic               sram_r_en_q;
    logic               sram_w_en_q;

    logic [SETS-1:0]    valid_q [2];
    logic [SETS-1:0]    lru_q;
    logic [TAG_W-1:0]   tag_q   [2][SETS];
    logic [63:0]        data_q  [2][SETS];

    logic [EFF_W-1:0]   eff_s;
    logic [IDX_W-1:0]   idx_s;
    logic [TAG_W-1:0]   tag_s;
    logic               wsel_s;
    logic [1:0]         way_hit_s;
    logic               hit_s;
    logic               hit_way_s;
    logic               victim_s;
    logic [63:0]        hit_line_s;
    logic               fill_done_s;
    logic               write_done_s;
    logic               read_hit_s;
    logic               write_hit_upd_s;
    logic               unused_s;

    // Byte-offset bits never take part in the lookup; base is word aligned,
    // so only the word-address bits need the modular subtraction.
    assign unused_s = ^address[1:0];
    assign eff_s    = address[EFF_W+1:2] - BASE_ADDR[EFF_W+1:2];
    assign wsel_s   = eff_s[0];
    assign idx_s    = eff_s[1 +: IDX_W];
    assign tag_s    = eff_s[1+IDX_W +: TAG_W];

    assign way_hit_s[0]    = valid_q[0][idx_s] && (tag_q[0][idx_s] == tag_s);
    assign way_hit_s[1]    = valid_q[1][idx_s] && (tag_q[1][idx_s] == tag_s);
    assign hit_s           = (MEM_R_EN | MEM_W_EN) && (|way_hit_s);
    assign hit_way_s       = ~way_hit_s[0];
    assign hit_line_s      = data_q[hit_way_s][idx_s];
    assign victim_s        = !valid_q[0][idx_s] ? 1'b0 :
                             (!valid_q[1][idx_s] ? 1'b1 : lru_q[idx_s]);

    assign fill_done_s     = (state_q == FILL)  && sram_ready;
    assign write_done_s    = (state_q == WRITE) && sram_ready;
    assign read_hit_s      = (state_q == IDLE) && MEM_R_EN && !MEM_W_EN && hit_s;
    assign write_hit_upd_s = write_done_s && hit_s;

    assign sram_r_en    = sram_r_en_q;
    assign sram_w_en    = sram_w_en_q;
    assign sram_wdata   = writeData;
    assign sram_address = (state_q == WRITE) ? {address[31:2], 2'b00}
                                             : {address[31:3], 3'b000};

    // Completion handshake and load data (hits and fill bypass are same-cycle).
    always_comb begin
        ready    = 1'b0;
        readData = 32'd0;
        case (state_q)
            IDLE: begin
                if (MEM_W_EN) begin
                    ready = 1'b0;
                end else if (MEM_R_EN) begin
                    if (hit_s) begin
                        ready    = 1'b1;
                        readData = wsel_s ? hit_line_s[63:32] : hit_line_s[31:0];
                    end else begin
                        ready = 1'b0;
                    end
                end else begin
                    ready = 1'b1;
                end
            end
            FILL: begin
                if (sram_ready) begin
                    ready    = 1'b1;
                    readData = wsel_s ? sram_rdata[63:32] : sram_rdata[31:0];
                end else begin
                    ready = 1'b0;
                end
            end
            WRITE: begin
                ready = sram_ready;
            end
            default: begin
                ready = 1'b0;
            end
        endcase
    end

    // Control FSM with registered SRAM enables.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sram_r_en_q <= 1'b0;
            sram_w_en_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (MEM_W_EN) begin
                        state_q     <= WRITE;
                        sram_w_en_q <= 1'b1;
                    end else if (MEM_R_EN && !hit_s) begin
                        state_q     <= FILL;
                        sram_r_en_q <= 1'b1;
                    end
                end
                FILL: begin
                    if (sram_ready) begin
                        state_q     <= IDLE;
                        sram_r_en_q <= 1'b0;
                    end
                end
                WRITE: begin
                    if (sram_ready) begin
                        state_q     <= IDLE;
                        sram_w_en_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    sram_r_en_q <= 1'b0;
                    sram_w_en_q <= 1'b0;
                end
            endcase
        end
    end

    // Valid and replacement state; the lru bit names the way to evict next.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q[0] <= {SETS{1'b0}};
            valid_q[1] <= {SETS{1'b0}};
            lru_q      <= {SETS{1'b0}};
        end else if (fill_done_s) begin
            valid_q[victim_s][idx_s] <= 1'b1;
            lru_q[idx_s]             <= ~victim_s;
        end else if (read_hit_s || write_hit_upd_s) begin
            lru_q[idx_s] <= ~hit_way_s;
        end
    end

    // Tag and data arrays; not reset, but a reset cycle still blocks updates.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (fill_done_s) begin
                tag_q[victim_s][idx_s]  <= tag_s;
                data_q[victim_s][idx_s] <= sram_rdata;
            end else if (write_hit_upd_s) begin
                if (wsel_s) begin
                    data_q[hit_way_s][idx_s][63:32] <= writeData;
                end else begin
                    data_q[hit_way_s][idx_s][31:0]  <= writeData;
                end
            end
        end
    end

endmodule
